trap_unit: RTL
==============

Name: trap_unit

Overview:
- Machine-mode trap responder for the riscv64i core.
- Consumes the CPU exception vector (ECALL, EBREAK, fetch/decode/anomaly errors) and the current PC/instruction.
- Latches mepc/mcause/mtval and issues a one-cycle PC redirect to mtvec; on MRET, redirects back to mepc.
- Owns the M-mode trap CSRs. Sits between CPU and PC, replacing the top-level HALT-on-ECALL monitor.

Parameters:
- DATA_WIDTH, 64, width of PC and CSRs
- INST_WIDTH, 32, instruction width (mtval source for illegal instruction)

Ports:
- clk_i  in  1  core clock (PLL output)
- rst_i  in  1  asynchronous, active-low reset
- exception_i  in  8  bit0 fetch err, bit1 decode err, bit2 anomaly, bit3 ECALL, bit4 EBREAK, bits7:5 reserved (ignored)
- pc_i  in  DATA_WIDTH  PC of the instruction raising the exception
- inst_i  in  INST_WIDTH  instruction word at pc_i
- mret_i  in  1  CPU decoded MRET this cycle
- csr_we_i  in  1  CSR write strobe
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  DATA_WIDTH  CSR write data
- csr_rdata_o  out  DATA_WIDTH  combinational read of csr_addr_i; 0 for unmapped addresses
- redirect_o  out  1  one-cycle pulse: PC loads redirect_pc_o
- redirect_pc_o  out  DATA_WIDTH  redirect target
- stall_o  out  1  PC write-enable inhibit
- halted_o  out  1  core halted; sticky until reset

Behaviour:
- CSRs: mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343. All reset to 0.
- Write masking: mtvec[1:0] forced 0 (direct mode only); mepc[1:0] forced 0.
- Reset values: redirect_o=0, redirect_pc_o=0, stall_o=0, halted_o=0, state=IDLE.
- States: IDLE, REDIRECT, HALT.
- Exception priority, with (mcause, mtval):
  - fetch err: (1, pc_i)
  - decode err: (2, zero-extended inst_i)
  - anomaly: (5, 0)
  - ECALL: (11, 0)
  - EBREAK: (3, pc_i)
- IDLE, cycle N, any of exception_i[4:0] set:
  - If mtvec==0: go HALT at N+1. CSRs are still latched.
  - Else: latch mepc=pc_i, mcause, mtval. Go REDIRECT at N+1.
- IDLE, mret_i and no exception: go REDIRECT at N+1 with target mepc. MRET does not modify CSRs.
- REDIRECT (one cycle): redirect_o=1, redirect_pc_o=target (mtvec or mepc), stall_o=1. Returns to IDLE at N+2. exception_i and mret_i are ignored in this state.
- Outputs are registered; redirect_pc_o holds its last target when redirect_o=0.
- HALT: stall_o=1, halted_o=1. Only rst_i exits. CSR reads still work; CSR writes are ignored.
- Simultaneous events:
  - Exception and mret_i: exception wins.
  - Exception and CSR write in the same cycle: the trap latch wins for mepc/mcause/mtval. Writes to mtvec/mscratch complete.
  - Software CSR write to mepc with no trap: takes effect at the next edge.
- Reset mid-REDIRECT: immediate return to IDLE with all outputs 0. CSRs are cleared.
- Exception in IDLE with stall_o=0: the CPU must not commit the faulting instruction. stall_o is driven combinationally high when state==IDLE and exception_i[4:0]!=0.

Optional Feature:
- Macro TRAP_COUNT_EN.
- Defined: a 64-bit read-only counter at CSR 0x7C0.
  - Increments once per trap entry, including entries that lead to HALT. Does not increment on MRET.
  - Wraps modulo 2^64. Reset value 0. Writes are ignored.
- Undefined: 0x7C0 reads 0; no counter logic is generated.

Decomposition:
- trap_pkg holds:
  - exception bit indices (FETCH_ERR=0, DECODE_ERR=1, ANOMALY=2, ECALL=3, EBREAK=4)
  - cause codes
  - CSR address constants
  - trap_state_e enum {IDLE, REDIRECT, HALT}
- Sub-module trap_csr_file: CSR storage, write masking, read mux, and the optional counter. trap_unit keeps the FSM and priority encoder.

Test Plan:
- mtvec=0x80001000; ECALL with pc_i=0x80000040 -> at N+1: redirect_o=1, redirect_pc_o=0x80001000, mepc=0x80000040, mcause=11, mtval=0.
- Then mret_i=1 -> next cycle: redirect_o=1, redirect_pc_o=0x80000040; mcause unchanged at 11.
- Decode and EBREAK together (exception_i=0x12), inst_i=0xFFFFFFFF -> mcause=2, mtval=0x00000000FFFFFFFF.
- mtvec=0; EBREAK -> halted_o=1 and stall_o=1 from N+1; a later write of mtvec=0x100 is ignored; rst_i low clears halted_o.
- Write mtvec=0x80000203 -> reads back 0x80000200. Simultaneous ECALL and CSR write mepc=0x1234 -> mepc=pc_i.
- TRAP_COUNT_EN defined: 3 traps and 2 MRETs -> CSR 0x7C0 reads 3. rst_i pulsed low during REDIRECT -> redirect_o=0 immediately.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap unit: exception bit indices,
// cause codes, CSR addresses and the FSM state type.
package trap_pkg;

  localparam int EXC_FETCH_ERR  = 0;
  localparam int EXC_DECODE_ERR = 1;
  localparam int EXC_ANOMALY    = 2;
  localparam int EXC_ECALL      = 3;
  localparam int EXC_EBREAK     = 4;

  localparam logic [3:0] CAUSE_FETCH_ERR  = 4'd1;
  localparam logic [3:0] CAUSE_DECODE_ERR = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK     = 4'd3;
  localparam logic [3:0] CAUSE_ANOMALY    = 4'd5;
  localparam logic [3:0] CAUSE_ECALL      = 4'd11;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_TRAP_CNT = 12'h7C0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    HALT     = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// M-mode trap CSR storage with write masking and combinational read mux.
// The trap-entry counter at 0x7C0 exists only when TRAP_COUNT_EN is defined.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [11:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_trap,
  input  logic [DATA_WIDTH-1:0] i_trap_mepc,
  input  logic [3:0]            i_trap_mcause,
  input  logic [DATA_WIDTH-1:0] i_trap_mtval,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [DATA_WIDTH-1:0] o_mtvec,
  output logic [DATA_WIDTH-1:0] o_mepc
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));

  logic [DATA_WIDTH-1:0] r_mtvec;
  logic [DATA_WIDTH-1:0] r_mscratch;
  logic [DATA_WIDTH-1:0] r_mepc;
  logic [DATA_WIDTH-1:0] r_mcause;
  logic [DATA_WIDTH-1:0] r_mtval;

  // A trap latch overrides software writes to the trap-state CSRs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else begin
      if (i_we && i_addr == CSR_MTVEC)    r_mtvec    <= i_wdata & ALIGN_MASK;
      if (i_we && i_addr == CSR_MSCRATCH) r_mscratch <= i_wdata;
      if (i_trap) begin
        r_mepc   <= i_trap_mepc & ALIGN_MASK;
        r_mcause <= DATA_WIDTH'(i_trap_mcause);
        r_mtval  <= i_trap_mtval;
      end else if (i_we) begin
        if (i_addr == CSR_MEPC)   r_mepc   <= i_wdata & ALIGN_MASK;
        if (i_addr == CSR_MCAUSE) r_mcause <= i_wdata;
        if (i_addr == CSR_MTVAL)  r_mtval  <= i_wdata;
      end
    end
  end

`ifdef TRAP_COUNT_EN
  logic [DATA_WIDTH-1:0] r_trap_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trap_cnt <= '0;
    end else if (i_trap) begin
      r_trap_cnt <= r_trap_cnt + DATA_WIDTH'(1);
    end
  end
`endif

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CSR_MTVEC:    o_rdata = r_mtvec;
      CSR_MSCRATCH: o_rdata = r_mscratch;
      CSR_MEPC:     o_rdata = r_mepc;
      CSR_MCAUSE:   o_rdata = r_mcause;
      CSR_MTVAL:    o_rdata = r_mtval;
`ifdef TRAP_COUNT_EN
      CSR_TRAP_CNT: o_rdata = r_trap_cnt;
`endif
      default:      o_rdata = '0;
    endcase
  end

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap responder: priority-encodes exceptions, redirects the PC to
// mtvec/mepc, halts when mtvec is unset. Optional counter via TRAP_COUNT_EN.
module trap_unit
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            exception_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic                  mret_i,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  stall_o,
  output logic                  halted_o
);

  trap_state_e           r_state;
  logic                  r_redirect;
  logic [DATA_WIDTH-1:0] r_redirect_pc;
  logic                  r_stall;
  logic                  r_halted;

  logic                  w_exc_any;
  logic                  w_trap;
  logic [3:0]            w_cause;
  logic [DATA_WIDTH-1:0] w_tval;
  logic [DATA_WIDTH-1:0] w_mtvec;
  logic [DATA_WIDTH-1:0] w_mepc;

  // Reserved bits 7:5 are masked off here and never reach the encoder.
  assign w_exc_any = |(exception_i & 8'h1F);
  assign w_trap    = (r_state == IDLE) && w_exc_any;

  always_comb begin
    w_cause = 4'd0;
    w_tval  = '0;
    if (exception_i[EXC_FETCH_ERR]) begin
      w_cause = CAUSE_FETCH_ERR;
      w_tval  = pc_i;
    end else if (exception_i[EXC_DECODE_ERR]) begin
      w_cause = CAUSE_DECODE_ERR;
      w_tval  = {{(DATA_WIDTH-INST_WIDTH){1'b0}}, inst_i};
    end else if (exception_i[EXC_ANOMALY]) begin
      w_cause = CAUSE_ANOMALY;
      w_tval  = '0;
    end else if (exception_i[EXC_ECALL]) begin
      w_cause = CAUSE_ECALL;
      w_tval  = '0;
    end else if (exception_i[EXC_EBREAK]) begin
      w_cause = CAUSE_EBREAK;
      w_tval  = pc_i;
    end else begin
      w_cause = 4'd0;
      w_tval  = '0;
    end
  end

  trap_csr_file #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csr (
    .i_clk         (clk_i),
    .i_rst_n       (rst_i),
    .i_we          (csr_we_i && (r_state != HALT)),
    .i_addr        (csr_addr_i),
    .i_wdata       (csr_wdata_i),
    .i_trap        (w_trap),
    .i_trap_mepc   (pc_i),
    .i_trap_mcause (w_cause),
    .i_trap_mtval  (w_tval),
    .o_rdata       (csr_rdata_o),
    .o_mtvec       (w_mtvec),
    .o_mepc        (w_mepc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= IDLE;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_stall       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_exc_any && (w_mtvec == '0)) begin
            r_state  <= HALT;
            r_stall  <= 1'b1;
            r_halted <= 1'b1;
          end else if (w_exc_any) begin
            r_state       <= REDIRECT;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_mtvec;
            r_stall       <= 1'b1;
          end else if (mret_i) begin
            r_state       <= REDIRECT;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_mepc;
            r_stall       <= 1'b1;
          end else begin
            r_redirect <= 1'b0;
            r_stall    <= 1'b0;
          end
        end
        REDIRECT: begin
          r_state    <= IDLE;
          r_redirect <= 1'b0;
          r_stall    <= 1'b0;
        end
        HALT: begin
          r_state    <= HALT;
          r_redirect <= 1'b0;
          r_stall    <= 1'b1;
          r_halted   <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_redirect <= 1'b0;
          r_stall    <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  // The faulting instruction must not commit in the cycle the exception is seen.
  assign stall_o       = r_stall | w_trap;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign halted_o      = r_halted;

endmodule
